// File: rtl/fifo_stat_t_pkg.sv
// Shared defaults, read-mode constants and operation decode for fifo_stat_t.
package fifo_stat_t_pkg;

    localparam int FIFO_DEF_B      = 8;
    localparam int FIFO_DEF_W      = 4;
    localparam int FIFO_DEF_AF_LVL = 12;
    localparam int FIFO_DEF_AE_LVL = 2;

    localparam int FIFO_MODE_REG  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_SWAP = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e fifo_op(
        input logic push,
        input logic pop
    );
        return fifo_op_e'({pop, push});
    endfunction

endpackage

// File: rtl/fifo_regfile_t.sv
// FIFO storage: one write port on the falling clock edge,
// one asynchronous read port.
module fifo_regfile_t
    import fifo_stat_t_pkg::*;
#(
    parameter int B = FIFO_DEF_B,
    parameter int W = FIFO_DEF_W
) (
    input  logic         clk,
    input  logic         we,
    input  logic [W-1:0] w_addr,
    input  logic [B-1:0] w_data,
    input  logic [W-1:0] r_addr,
    output logic [B-1:0] r_data
);

    logic [B-1:0] mem [2**W];

    always_ff @(negedge clk) begin
        if (we) begin
            mem[w_addr] <= w_data;
        end
    end

    assign r_data = mem[r_addr];

endmodule

// File: rtl/fifo_stat_t.sv
// Synchronous FIFO with occupancy count, level flags, sticky errors,
// flush and selectable first-word-fall-through / registered read.
module fifo_stat_t
    import fifo_stat_t_pkg::*;
#(
    parameter int B      = FIFO_DEF_B,
    parameter int W      = FIFO_DEF_W,
    parameter int AF_LVL = FIFO_DEF_AF_LVL,
    parameter int AE_LVL = FIFO_DEF_AE_LVL,
    parameter int FWFT   = FIFO_MODE_FWFT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         wr,
    input  logic [B-1:0] w_data,
    input  logic         rd,
    output logic [B-1:0] r_data,
    output logic         r_valid,
    output logic         empty,
    output logic         full,
    output logic         almost_empty,
    output logic         almost_full,
    output logic [W:0]   count,
    output logic         overflow,
    output logic         underflow
);

    localparam int D = 1 << W;
    localparam logic [W:0] CNT_FULL = D[W:0];
    localparam logic [W:0] CNT_AF   = AF_LVL[W:0];
    localparam logic [W:0] CNT_AE   = AE_LVL[W:0];

    if (AF_LVL < 1 || AF_LVL > D) begin : g_bad_af
        initial $error("fifo_stat_t: AF_LVL out of range 1..D");
    end
    if (AE_LVL < 0 || AE_LVL > D - 1) begin : g_bad_ae
        initial $error("fifo_stat_t: AE_LVL out of range 0..D-1");
    end

    logic [W-1:0] w_ptr;
    logic [W-1:0] r_ptr;
    logic [W:0]   cnt_q;
    logic [W:0]   cnt_next;
    logic         empty_q;
    logic         full_q;
    logic         ae_q;
    logic         af_q;
    logic         ovf_q;
    logic         unf_q;
    logic         rd_acc;
    logic         wr_acc;
    logic         we;
    logic [B-1:0] rf_rdata;
    fifo_op_e     op;

    // A write into a full FIFO is still taken when a read frees a slot.
    always_comb begin
        rd_acc = rd & ~empty_q;
        wr_acc = wr & (~full_q | rd_acc);
        op     = fifo_op(wr_acc, rd_acc);
    end

    always_comb begin
        cnt_next = cnt_q;
        unique case (op)
            OP_PUSH: cnt_next = cnt_q + 1'b1;
            OP_POP:  cnt_next = cnt_q - 1'b1;
            default: cnt_next = cnt_q;
        endcase
    end

    assign we = wr_acc & reset & ~clr;

    fifo_regfile_t #(
        .B (B),
        .W (W)
    ) u_regfile (
        .clk    (clk),
        .we     (we),
        .w_addr (w_ptr),
        .w_data (w_data),
        .r_addr (r_ptr),
        .r_data (rf_rdata)
    );

    always_ff @(negedge clk) begin
        if (!reset || clr) begin
            w_ptr   <= '0;
            r_ptr   <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ae_q    <= 1'b1;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            if (wr_acc) begin
                w_ptr <= w_ptr + 1'b1;
            end
            if (rd_acc) begin
                r_ptr <= r_ptr + 1'b1;
            end
            cnt_q   <= cnt_next;
            empty_q <= (cnt_next == '0);
            full_q  <= (cnt_next == CNT_FULL);
            ae_q    <= (cnt_next <= CNT_AE);
            af_q    <= (cnt_next >= CNT_AF);
            if (wr & ~wr_acc) begin
                ovf_q <= 1'b1;
            end
            if (rd & empty_q) begin
                unf_q <= 1'b1;
            end
        end
    end

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        assign r_data  = rf_rdata;
        assign r_valid = ~empty_q;
    end else begin : g_reg
        logic [B-1:0] rdata_q;
        logic         rvalid_q;

        // Flush drops the pending valid but keeps the last word.
        always_ff @(negedge clk) begin
            if (!reset) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else if (clr) begin
                rvalid_q <= 1'b0;
            end else begin
                rvalid_q <= rd_acc;
                if (rd_acc) begin
                    rdata_q <= rf_rdata;
                end
            end
        end

        assign r_data  = rdata_q;
        assign r_valid = rvalid_q;
    end

    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_empty = ae_q;
    assign almost_full  = af_q;
    assign count        = cnt_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_stat_t.sv
// Random and directed checks of fifo_stat_t in both read modes
// against a queue-based reference model.
module tb_fifo_stat_t;

    localparam int D = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clr = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] w_data = 8'h00;
    logic       rd = 1'b0;

    logic [7:0] f_r_data, g_r_data;
    logic       f_r_valid, g_r_valid;
    logic       f_empty, g_empty, f_full, g_full;
    logic       f_ae, g_ae, f_af, g_af;
    logic [4:0] f_count, g_count;
    logic       f_ovf, g_ovf, f_unf, g_unf;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fifo_stat_t #(.B(8), .W(4), .AF_LVL(12), .AE_LVL(2), .FWFT(1)) u_fwft (
        .clk(clk), .reset(reset), .clr(clr), .wr(wr), .w_data(w_data),
        .rd(rd), .r_data(f_r_data), .r_valid(f_r_valid), .empty(f_empty),
        .full(f_full), .almost_empty(f_ae), .almost_full(f_af),
        .count(f_count), .overflow(f_ovf), .underflow(f_unf)
    );

    fifo_stat_t #(.B(8), .W(4), .AF_LVL(12), .AE_LVL(2), .FWFT(0)) u_reg (
        .clk(clk), .reset(reset), .clr(clr), .wr(wr), .w_data(w_data),
        .rd(rd), .r_data(g_r_data), .r_valid(g_r_valid), .empty(g_empty),
        .full(g_full), .almost_empty(g_ae), .almost_full(g_af),
        .count(g_count), .overflow(g_ovf), .underflow(g_unf)
    );

    // Reference model: contents as a queue, updated on the falling edge.
    logic [7:0] q[$];
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;
    logic       m_rv = 1'b0;
    logic [7:0] m_rdata = 8'h00;
    bit         armed = 1'b0;

    always @(negedge clk) begin
        bit do_rd, do_wr;
        if (!reset) begin
            q.delete();
            m_ovf = 1'b0; m_unf = 1'b0;
            m_rv = 1'b0; m_rdata = 8'h00;
            armed = 1'b1;
        end else if (clr) begin
            q.delete();
            m_ovf = 1'b0; m_unf = 1'b0; m_rv = 1'b0;
        end else begin
            do_rd = rd && (q.size() > 0);
            do_wr = wr && ((q.size() < D) || do_rd);
            if (rd && q.size() == 0) m_unf = 1'b1;
            if (wr && !do_wr) m_ovf = 1'b1;
            m_rv = do_rd;
            if (do_rd) m_rdata = q.pop_front();
            if (do_wr) q.push_back(w_data);
        end
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(posedge clk) begin
        int n;
        if (armed) begin
            n = q.size();
            chk("f_count", 32'(f_count), 32'(n));
            chk("g_count", 32'(g_count), 32'(n));
            chk("f_empty", 32'(f_empty), 32'(n == 0));
            chk("g_empty", 32'(g_empty), 32'(n == 0));
            chk("f_full", 32'(f_full), 32'(n == D));
            chk("g_full", 32'(g_full), 32'(n == D));
            chk("f_ae", 32'(f_ae), 32'(n <= 2));
            chk("g_ae", 32'(g_ae), 32'(n <= 2));
            chk("f_af", 32'(f_af), 32'(n >= 12));
            chk("g_af", 32'(g_af), 32'(n >= 12));
            chk("f_ovf", 32'(f_ovf), 32'(m_ovf));
            chk("g_ovf", 32'(g_ovf), 32'(m_ovf));
            chk("f_unf", 32'(f_unf), 32'(m_unf));
            chk("g_unf", 32'(g_unf), 32'(m_unf));
            chk("f_r_valid", 32'(f_r_valid), 32'(n != 0));
            if (n != 0) chk("f_r_data", 32'(f_r_data), 32'(q[0]));
            chk("g_r_valid", 32'(g_r_valid), 32'(m_rv));
            chk("g_r_data", 32'(g_r_data), 32'(m_rdata));
        end
    end

    task automatic drv(input logic rs, input logic c, input logic w,
                       input logic [7:0] d, input logic r);
        #1;
        reset = rs; clr = c; wr = w; w_data = d; rd = r;
        @(posedge clk);
    endtask

    initial begin
        int pw, pr;
        @(posedge clk);
        drv(0, 0, 0, 8'h00, 0);
        drv(0, 0, 0, 8'h00, 0);
        chk("rst_count", 32'(f_count), 0);
        chk("rst_empty", 32'(f_empty), 1);
        chk("rst_ae", 32'(f_ae), 1);
        chk("rst_rvalid", 32'(g_r_valid), 0);
        chk("rst_rdata", 32'(g_r_data), 0);

        // Fill 0x01..0x10.
        for (int i = 1; i <= 16; i++) begin
            drv(1, 0, 1, 8'(i), 0);
            chk("fill_count", 32'(f_count), 32'(i));
            chk("fill_head", 32'(f_r_data), 32'h01);
            if (i == 2) chk("ae_at2", 32'(f_ae), 1);
            if (i == 3) chk("ae_at3", 32'(f_ae), 0);
            if (i == 11) chk("af_at11", 32'(f_af), 0);
            if (i == 12) chk("af_at12", 32'(f_af), 1);
        end
        chk("full16", 32'(f_full), 1);

        // Overflow, then drain in order.
        drv(1, 0, 1, 8'hAA, 0);
        chk("ovf_count", 32'(f_count), 16);
        chk("ovf_set", 32'(f_ovf), 1);
        for (int k = 1; k <= 16; k++) begin
            chk("drain_head", 32'(f_r_data), 32'(k));
            drv(1, 0, 0, 8'h00, 1);
            chk("drain_reg", 32'(g_r_data), 32'(k));
        end
        drv(1, 0, 0, 8'h00, 0);
        chk("drain_empty", 32'(f_empty), 1);
        chk("drain_unf", 32'(f_unf), 0);
        chk("ovf_sticky", 32'(f_ovf), 1);

        // Simultaneous read/write when full.
        drv(1, 1, 0, 8'h00, 0);
        for (int i = 0; i < 16; i++) drv(1, 0, 1, 8'($urandom), 0);
        drv(1, 0, 1, 8'h55, 1);
        chk("swap_full_cnt", 32'(f_count), 16);
        chk("swap_full_ovf", 32'(f_ovf), 0);
        for (int i = 0; i < 15; i++) drv(1, 0, 0, 8'h00, 1);
        chk("last_is_55", 32'(f_r_data), 32'h55);
        drv(1, 0, 0, 8'h00, 1);
        chk("last_reg_55", 32'(g_r_data), 32'h55);

        // Simultaneous read/write when empty.
        drv(1, 0, 1, 8'h77, 1);
        chk("swap_empty_cnt", 32'(f_count), 1);
        chk("swap_empty_unf", 32'(f_unf), 1);
        chk("swap_empty_dat", 32'(f_r_data), 32'h77);

        // Wrap-around rounds.
        drv(1, 1, 0, 8'h00, 0);
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 3; i++) drv(1, 0, 1, 8'($urandom), 0);
            for (int i = 0; i < 3; i++) drv(1, 0, 0, 8'h00, 1);
            chk("wrap_cnt0", 32'(f_count), 0);
        end

        // Registered read mode.
        drv(1, 1, 0, 8'h00, 0);
        drv(1, 0, 1, 8'h3C, 0);
        drv(1, 0, 1, 8'hC3, 0);
        chk("reg_idle_rv", 32'(g_r_valid), 0);
        drv(1, 0, 0, 8'h00, 1);
        chk("reg_rv1", 32'(g_r_valid), 1);
        chk("reg_d1", 32'(g_r_data), 32'h3C);
        drv(1, 0, 0, 8'h00, 1);
        chk("reg_rv2", 32'(g_r_valid), 1);
        chk("reg_d2", 32'(g_r_data), 32'hC3);
        drv(1, 0, 0, 8'h00, 0);
        chk("reg_rv_off", 32'(g_r_valid), 0);
        chk("reg_hold", 32'(g_r_data), 32'hC3);

        // clr with wr at count 5 and overflow set.
        for (int i = 0; i < 17; i++) drv(1, 0, 1, 8'($urandom), 0);
        for (int i = 0; i < 11; i++) drv(1, 0, 0, 8'h00, 1);
        chk("pre_clr_cnt", 32'(f_count), 5);
        chk("pre_clr_ovf", 32'(f_ovf), 1);
        drv(1, 1, 1, 8'h99, 0);
        chk("clr_cnt", 32'(f_count), 0);
        chk("clr_empty", 32'(f_empty), 1);
        chk("clr_ovf", 32'(f_ovf), 0);

        // Reset mid-operation with wr.
        for (int i = 0; i < 3; i++) drv(1, 0, 1, 8'($urandom), 0);
        drv(0, 0, 1, 8'h11, 0);
        chk("mid_rst_cnt", 32'(f_count), 0);
        chk("mid_rst_ae", 32'(f_ae), 1);
        chk("mid_rst_af", 32'(f_af), 0);
        chk("mid_rst_rd", 32'(g_r_data), 0);

        // Randomized traffic with changing bias.
        pw = 50; pr = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) begin
                pw = $urandom_range(10, 90);
                pr = $urandom_range(10, 90);
            end
            drv($urandom_range(0, 199) != 0,
                $urandom_range(0, 99) == 0,
                $urandom_range(0, 99) < pw,
                8'($urandom),
                $urandom_range(0, 99) < pr);
        end
        drv(1, 0, 0, 8'h00, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
